// File: rtl/game_flow_ctrl_pkg.sv
// game_pkg: shared definitions for the game sequencer slice.
//   game_state_e  - FSM state encoding (START..WIN); codes 6/7 are illegal
//   SRC_*         - VGA source-mux indices
//   state_to_src  - maps a state code to its VGA source index
package game_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_MAZE   = 3'd1,
    ST_BATTLE = 3'd2,
    ST_LOSE   = 3'd3,
    ST_BOSS   = 3'd4,
    ST_WIN    = 3'd5
  } game_state_e;

  localparam logic [2:0] SRC_START  = 3'd0;
  localparam logic [2:0] SRC_MAZE   = 3'd1;
  localparam logic [2:0] SRC_BATTLE = 3'd2;
  localparam logic [2:0] SRC_BOSS   = 3'd4;
  localparam logic [2:0] SRC_WIN    = 3'd5;
  localparam logic [2:0] SRC_LOSE   = 3'd6;

  function automatic logic [2:0] state_to_src(input logic [2:0] s);
    logic [2:0] src;
    case (s)
      ST_START:  src = SRC_START;
      ST_MAZE:   src = SRC_MAZE;
      ST_BATTLE: src = SRC_BATTLE;
      ST_LOSE:   src = SRC_LOSE;
      ST_BOSS:   src = SRC_BOSS;
      ST_WIN:    src = SRC_WIN;
      default:   src = SRC_START;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: status inputs from the screen generators and the
// sequencer outputs toward the VGA mux.
//   master - environment side (drives status, observes sequencer)
//   slave  - game_flow_ctrl side
interface game_flow_ctrl_if;
  logic       start_sw;
  logic       frame_tick;
  logic       enemy_collide;
  logic       battle_win;
  logic       battle_dead;
  logic       boss_win;
  logic       boss_dead;
  logic [2:0] state;
  logic [2:0] src_sel;
  logic [6:0] screen_rst;
  logic [2:0] win_count;
  logic       boss_enable;

  modport master (
    output start_sw, frame_tick, enemy_collide, battle_win, battle_dead,
           boss_win, boss_dead,
    input  state, src_sel, screen_rst, win_count, boss_enable
  );

  modport slave (
    input  start_sw, frame_tick, enemy_collide, battle_win, battle_dead,
           boss_win, boss_dead,
    output state, src_sel, screen_rst, win_count, boss_enable
  );
endinterface

// File: rtl/game_flow_ctrl_rst_pulse_gen.sv
// rst_pulse_gen: load-on-trigger down-counter. A trig cycle loads HOLD;
// busy is high while the count is non-zero, i.e. for exactly HOLD cycles
// starting the cycle after trig.
//   clk, rst (async active-low), trig (load), busy (pulse active)
module rst_pulse_gen #(
  parameter int unsigned HOLD = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic busy
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (trig) begin
      cnt_q <= 8'(HOLD);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-state sequencer. Owns the START/MAZE/BATTLE/BOSS/
// WIN/LOSE FSM, counts battle wins to unlock the boss, selects the VGA
// source and pulses a per-screen reset on entry to BATTLE or BOSS.
//   clk, rst (async active-low)
//   bus (slave): status inputs in; state, src_sel, screen_rst,
//                win_count, boss_enable out
// Optional macro FRAME_ALIGN_EN: src_sel only updates on frame_tick.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned WINS_FOR_BOSS = 5,
  parameter int unsigned RST_HOLD      = 128
) (
  input  logic            clk,
  input  logic            rst,
  game_flow_ctrl_if.slave bus
);

  game_state_e state_q;
  logic [2:0]  win_q;
  logic        boss_en_q;
  logic        armed_q;
  logic        hold_busy;
  logic        hold_trig;
  logic [6:0]  screen_rst_c;

  // Entry into BATTLE or BOSS is only possible from MAZE; this mirrors the
  // MAZE branch below so the counter loads on the same edge as the state.
  always_comb begin
    hold_trig = (state_q == ST_MAZE) &&
                (boss_en_q || (bus.enemy_collide && armed_q));
  end

  rst_pulse_gen #(.HOLD(RST_HOLD)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .trig (hold_trig),
    .busy (hold_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_START;
      win_q     <= '0;
      boss_en_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_START: if (bus.start_sw) state_q <= ST_MAZE;
        ST_MAZE: begin
          if (!bus.enemy_collide) armed_q <= 1'b1;
          if (boss_en_q)                              state_q <= ST_BOSS;
          else if (bus.enemy_collide && armed_q)      state_q <= ST_BATTLE;
        end
        ST_BATTLE: begin
          // Status is ignored while the screen reset pulse is active.
          if (!hold_busy) begin
            if (bus.battle_dead) begin
              state_q <= ST_LOSE;
              armed_q <= 1'b0;
            end else if (bus.battle_win) begin
              state_q <= ST_MAZE;
              armed_q <= 1'b0;
              if (win_q != 3'(WINS_FOR_BOSS)) begin
                win_q <= win_q + 3'd1;
                if (win_q + 3'd1 == 3'(WINS_FOR_BOSS)) boss_en_q <= 1'b1;
              end
            end
          end
        end
        ST_BOSS: begin
          if (!hold_busy) begin
            if (bus.boss_dead)     state_q <= ST_LOSE;
            else if (bus.boss_win) state_q <= ST_WIN;
          end
        end
        ST_WIN, ST_LOSE: ;
        default: state_q <= ST_START;
      endcase
    end
  end

  // The FSM cannot leave BATTLE/BOSS while the pulse is busy, so the bit
  // can be steered from the current state without storing an index.
  always_comb begin
    screen_rst_c = '0;
    if (hold_busy) screen_rst_c[state_to_src(state_q)] = 1'b1;
  end

  assign bus.state       = state_q;
  assign bus.win_count   = win_q;
  assign bus.boss_enable = boss_en_q;
  assign bus.screen_rst  = screen_rst_c;

`ifdef FRAME_ALIGN_EN
  logic [2:0] src_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= SRC_START;
    end else if (bus.frame_tick) begin
      src_q <= state_to_src(state_q);
    end
  end
  assign bus.src_sel = src_q;
`else
  logic unused_frame_tick;
  assign unused_frame_tick = bus.frame_tick;
  assign bus.src_sel = state_to_src(state_q);
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  localparam int W    = 5;
  localparam int HOLD = 128;

  // Game modes, numbered by their state codes.
  localparam int M_START = 0, M_MAZE = 1, M_BATTLE = 2, M_LOSE = 3,
                 M_BOSS = 4, M_WIN = 5;

  typedef struct {
    int st;
    int src;
    int srst;
    int wins;
    int ben;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  game_flow_ctrl_if bus();

  game_flow_ctrl #(.WINS_FOR_BOSS(W), .RST_HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t q[$];
  int src_map [6] = '{0, 1, 2, 6, 4, 5};

  // Reference model state
  int m_mode = 0, m_hold = 0, m_wins = 0;
  bit m_armed = 1, m_ben = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_START; m_hold = 0; m_wins = 0; m_armed = 1; m_ben = 0;
    q.delete();
  endtask

  // One clock of game rules, applied to the inputs sampled at this edge.
  task automatic model_step();
    int  nm = m_mode, nw = m_wins;
    bit  na = m_armed, nb = m_ben, enter = 0;
    bit  quiet = (m_hold == 0);
    exp_t e;
    case (m_mode)
      M_START: if (bus.start_sw) nm = M_MAZE;
      M_MAZE: begin
        if (!bus.enemy_collide) na = 1;
        if (m_ben) begin nm = M_BOSS; enter = 1; end
        else if (bus.enemy_collide && m_armed) begin nm = M_BATTLE; enter = 1; end
      end
      M_BATTLE: if (quiet) begin
        if (bus.battle_dead) begin nm = M_LOSE; na = 0; end
        else if (bus.battle_win) begin
          nm = M_MAZE; na = 0;
          nw = (m_wins < W) ? m_wins + 1 : W;
          if (nw == W) nb = 1;
        end
      end
      M_BOSS: if (quiet) begin
        if (bus.boss_dead) nm = M_LOSE;
        else if (bus.boss_win) nm = M_WIN;
      end
      default: ;
    endcase
    m_hold  = enter ? HOLD : (m_hold > 0 ? m_hold - 1 : 0);
    m_mode  = nm; m_wins = nw; m_armed = na; m_ben = nb;
    e.st   = m_mode;
    e.src  = src_map[m_mode];
    e.srst = (m_hold > 0) ? (1 << src_map[m_mode]) : 0;
    e.wins = m_wins;
    e.ben  = m_ben;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // Monitor: every registered output is presented each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state",       int'(bus.state),       e.st);
        chk("src_sel",     int'(bus.src_sel),     e.src);
        chk("screen_rst",  int'(bus.screen_rst),  e.srst);
        chk("win_count",   int'(bus.win_count),   e.wins);
        chk("boss_enable", int'(bus.boss_enable), e.ben);
        chk("screen_rst_onehot", int'($countones(bus.screen_rst) <= 1), 1);
      end
    end
  end

  task automatic clear_inputs();
    bus.start_sw = 0; bus.frame_tick = 0; bus.enemy_collide = 0;
    bus.battle_win = 0; bus.battle_dead = 0; bus.boss_win = 0; bus.boss_dead = 0;
  endtask

  // Asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #3 rst = 0;
    clear_inputs();
    #1;
    chk("rst_state",       int'(bus.state),       0);
    chk("rst_src_sel",     int'(bus.src_sel),     0);
    chk("rst_screen_rst",  int'(bus.screen_rst),  0);
    chk("rst_win_count",   int'(bus.win_count),   0);
    chk("rst_boss_enable", int'(bus.boss_enable), 0);
    repeat (2) @(negedge clk);
    #3 rst = 1;
  endtask

  task automatic drive_random(input int dead_rate);
    @(negedge clk);
    #1;
    bus.start_sw   = ($urandom_range(3) == 0);
    bus.frame_tick = ($urandom_range(15) == 0);
    if ($urandom_range(7) == 0) bus.enemy_collide = ~bus.enemy_collide;
    bus.battle_win = ($urandom_range(5) == 0);
    bus.boss_win   = ($urandom_range(7) == 0);
    bus.battle_dead = (dead_rate > 0) && ($urandom_range(dead_rate - 1) == 0);
    bus.boss_dead   = (dead_rate > 0) && ($urandom_range(dead_rate - 1) == 0);
  endtask

  int rates [6] = '{0, 0, 64, 0, 8, 200};

  initial begin
    clear_inputs();
    repeat (2) @(negedge clk);
    #3 rst = 1;
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      if (ep == 2) begin
        // Reset in the middle of a screen-reset hold.
        int waited = 0;
        while (bus.screen_rst == '0 && waited < 4000) begin
          drive_random(0);
          waited++;
        end
        chk("hold_reached", int'(bus.screen_rst != '0), 1);
        repeat (20) drive_random(0);
        do_reset();
      end
      repeat (2000) drive_random(rates[ep]);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer. It owns the game-state FSM (start, maze, battle, boss, win, lose) and counts battle victories to unlock the boss. It drives the VGA source-select index into the screen mux and issues per-screen reset pulses, so each battle starts from a clean generator. It sits between the screen generators' status outputs and the RGB/HS/VS output mux.

## Interface
Parameters:
- WINS_FOR_BOSS, 5, number of battle wins that unlocks the boss (1..7)
- RST_HOLD, 128, cycles a screen reset pulse is held high (1..255)

Ports:
- clk  in  1  system/pixel-domain clock
- rst  in  1  asynchronous, active-low reset
- start_sw  in  1  start request (level)
- frame_tick  in  1  one-cycle pulse at the start of each vertical blank
- enemy_collide  in  1  maze reports player on an enemy (level)
- battle_win  in  1  battle screen won (level)
- battle_dead  in  1  battle screen lost (level)
- boss_win  in  1  boss battle won (level)
- boss_dead  in  1  boss battle lost (level)
- state  out  3  current FSM state code
- src_sel  out  3  VGA source index: 0 start, 1 maze, 2 battle, 4 boss, 5 win, 6 lose
- screen_rst  out  7  active-high reset pulse per source index
- win_count  out  3  battles won, saturating at WINS_FOR_BOSS
- boss_enable  out  1  high once win_count reaches WINS_FOR_BOSS

## Operation
- State codes: START=0, MAZE=1, BATTLE=2, LOSE=3, BOSS=4, WIN=5. Code 6 and code 7 are illegal and recover to START.
- START → MAZE when start_sw=1.
- MAZE:
  - boss_enable=1 → BOSS. This has priority.
  - Otherwise enemy_collide=1 and collide_armed=1 → BATTLE.
- collide_armed is cleared on leaving BATTLE. It is set again once enemy_collide has been seen low in MAZE, so one collision yields exactly one battle.
- BATTLE:
  - battle_dead=1 → LOSE.
  - Else battle_win=1 → MAZE, with win_count incremented (saturating).
  - If battle_dead and battle_win are both high in the same cycle, dead wins.
- boss_enable is registered high in the same cycle win_count reaches WINS_FOR_BOSS. It clears only on reset.
- BOSS:
  - boss_dead=1 → LOSE (dead has priority).
  - Else boss_win=1 → WIN.
- WIN and LOSE are terminal until rst.
- On every entry into BATTLE or BOSS, screen_rst[src index] is held high for RST_HOLD cycles. A hold counter runs during this time. While the hold is active, all win/dead inputs are ignored, which masks stale status from the previous fight.
- Only one screen_rst bit is ever high. The other bits are always 0.

## Timing
- Reset values:
  - state=START, src_sel=0, screen_rst=0, win_count=0, boss_enable=0.
  - collide_armed=1, hold counter=0.
- Every output is registered. An input sampled high at cycle N produces the new state at N+1.
- screen_rst rises at N+1, together with the state change. It falls after exactly RST_HOLD cycles at 1. Status inputs are honoured from the first cycle screen_rst is 0.
- win_count and boss_enable update at N+1 with the BATTLE→MAZE transition.
- With no frame alignment, src_sel updates at N+1, alongside state.
- rst asserted mid-hold: the counter and screen_rst clear immediately (asynchronously).
- A frame_tick coincident with a state change: the tick applies to the new state (see Configuration).

## Configuration
- FRAME_ALIGN_EN defined:
  - src_sel loads the mapped index of the current state only on cycles with frame_tick=1. The new value is visible the cycle after the tick.
  - A state change in the same cycle as the tick is captured, giving a one-tick maximum delay to the display switch.
  - The state and screen_rst timing are unaffected.
- FRAME_ALIGN_EN undefined: src_sel follows state combinationally from the state register (same cycle as state). frame_tick is unused.

## Structure
- Shared package game_pkg holds:
  - the state encoding (START..WIN)
  - the source index constants (SRC_START=0 … SRC_LOSE=6)
  - the state→source mapping function
- One sub-module, rst_pulse_gen: a load-on-trigger down-counter producing a RST_HOLD-cycle pulse with a busy flag. It is instantiated once and steered to the screen_rst bit by the FSM.

## Test plan
- Reset, then start_sw=1 for 1 cycle → state=1 and src_sel=1 at the next edge. screen_rst=0.
- In MAZE, enemy_collide=1 → state=2, and screen_rst=7'b0000100 for exactly 128 cycles. A battle_win pulse during the hold is ignored (state stays 2).
- After the hold, battle_win=1 with enemy_collide still high → state=1 and win_count=1. With enemy_collide held high, no re-entry to state 2 occurs until it drops and rises again.
- Run 5 wins → win_count=5 and boss_enable=1 on the 5th return. The next cycle gives state=4 and screen_rst[4] high for 128 cycles. Then boss_win → state=5, src_sel=5.
- In BATTLE after the hold, battle_win=1 and battle_dead=1 together → state=3, src_sel=6, win_count unchanged.
- With FRAME_ALIGN_EN: state changes at cycle 10 and frame_tick pulses at cycle 40 → src_sel holds its old value through cycle 40 and takes the new value at cycle 41.
